// File: rtl/quiz2_pkg.sv
// Shared types and helpers for the quiz2 counter library and its
// sequencing front end.
package quiz2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index/count width for a range of n values; never below one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin picker: the first set request at or above
// ptr, wrapping, returned both one-hot and as an index.
module rr_arbiter
  import quiz2_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int PW    = width_of(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx
);

  logic found;
  int   pos;

  // NOTE: every output of a combinational block is given a default before
  // any conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Shares one up-counter among N_REQ requesters: round-robin grant, run the
// counter from 0 to the owner's latched limit, pulse done to the owner.
module counter_sched
  import quiz2_pkg::*;
#(
  parameter  int MAX_VAL = 16,
  parameter  int N_REQ   = 4,
  localparam int W       = width_of(MAX_VAL),
  localparam int PW      = width_of(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] limit,
  input  logic               abort,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic [W-1:0]       count,
  output logic [N_REQ-1:0]   done
);

  state_t           state_q, state_d;
  logic [W-1:0]     count_q, count_d;
  logic [W-1:0]     lim_q,   lim_d;
  logic [N_REQ-1:0] gnt_q,   gnt_d;
  logic [N_REQ-1:0] done_q,  done_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    ptr_q,   ptr_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [PW-1:0]    arb_idx;
  logic [PW-1:0]    ptr_after_owner;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Search for the next grant starts just past the job that last held the counter.
  assign ptr_after_owner = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lim_d   = lim_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = RUN;
          gnt_d   = arb_gnt;
          owner_d = arb_idx;
          lim_d   = limit[int'(arb_idx)*W +: W];
          count_d = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          gnt_d   = '0;
          count_d = '0;
          ptr_d   = ptr_after_owner;
        end else if (count_q == lim_q) begin
          state_d = DONE;
          done_d  = gnt_q;
        end else begin
          count_d = count_q + W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        count_d = '0;
        ptr_d   = ptr_after_owner;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        count_d = '0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      lim_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lim_q   <= lim_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt   = gnt_q;
  assign count = count_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);

endmodule
